// File: rtl/demux_dispatch_pkg.sv
// rtl/demux_dispatch_pkg.sv - shared types and constants for the 1-to-8 dispatch controller
package demux_dispatch_pkg;

  localparam int N  = 8;
  localparam int SW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SEND = 2'd2
  } state_t;

  function automatic logic [N-1:0] onehot(input logic [SW-1:0] i);
    return N'(1) << i;
  endfunction

endpackage

// File: rtl/demux_dispatch_ctrl_rr_pick8.sv
// rtl/demux_dispatch_ctrl_rr_pick8.sv - 8-way circular first-one finder starting after ptr
module rr_pick8
  import demux_dispatch_pkg::*;
(
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          found,
  output logic [SW-1:0] idx
);

  logic [SW-1:0] j;

  // Walk from farthest to nearest so the closest request after ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = N; k >= 1; k--) begin
      j = ptr + SW'(k);
      if (req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// rtl/demux_dispatch_ctrl.sv - single-source to 8-destination dispatch FSM with delivery counters
module demux_dispatch_ctrl
  import demux_dispatch_pkg::*;
#(
  parameter int DW    = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [SW-1:0]    in_dest,
  input  logic             mode,
  input  logic [N-1:0]     en_mask,
  output logic [SW-1:0]    sel,
  output logic [N-1:0]     out_valid,
  output logic [DW-1:0]    out_data,
  input  logic [N-1:0]     out_ready,
  output logic             drop_err,
  input  logic             cnt_clr,
  output logic [N*CNT_W-1:0] tx_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t        state;
  logic [DW-1:0] data_q;
  logic          rr_mode;
  logic [SW-1:0] ptr;
  logic [CNT_W-1:0] cnt [N];

  logic          pick_found;
  logic [SW-1:0] pick_idx;
  logic          deliver;

  rr_pick8 u_pick (
    .req   (en_mask & out_ready),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign deliver = (state == SEND) && out_ready[sel];

  for (genvar g = 0; g < N; g++) begin : g_cnt
    assign tx_count[g*CNT_W +: CNT_W] = cnt[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      sel       <= '0;
      out_valid <= '0;
      out_data  <= '0;
      drop_err  <= 1'b0;
      data_q    <= '0;
      rr_mode   <= 1'b0;
      ptr       <= SW'(N - 1);
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      drop_err <= 1'b0;
      // Clear takes priority over a delivery landing in the same cycle.
      for (int i = 0; i < N; i++) begin
        if (cnt_clr)
          cnt[i] <= '0;
        else if (deliver && sel == SW'(i) && cnt[i] != CNT_MAX)
          cnt[i] <= cnt[i] + 1'b1;
      end
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data_q  <= in_data;
            rr_mode <= mode;
            if (!mode) begin
              if (en_mask[in_dest]) begin
                sel       <= in_dest;
                out_valid <= onehot(in_dest);
                out_data  <= in_data;
                in_ready  <= 1'b0;
                state     <= SEND;
              end else begin
                drop_err <= 1'b1;
              end
            end else if (en_mask == '0) begin
              drop_err <= 1'b1;
            end else begin
              in_ready <= 1'b0;
              state    <= ARB;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        ARB: begin
          if (pick_found) begin
            sel       <= pick_idx;
            out_valid <= onehot(pick_idx);
            out_data  <= data_q;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready[sel]) begin
            if (rr_mode) ptr <= sel;
            out_valid <= '0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
